// File: rtl/rf_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_fifo_pkg
// Description : Shared sizing functions and pointer-compare helpers for the
//               register-file FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  // Number of storage entries addressed by aw bits.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Pointers are equal including the wrap bit: nothing stored.
  function automatic logic ptrs_empty(input logic [31:0] wr, input logic [31:0] rd);
    return (wr == rd);
  endfunction

  // Address bits equal and wrap bits differ: every entry holds live data.
  function automatic logic ptrs_full(input int unsigned aw,
                                     input logic [31:0] wr,
                                     input logic [31:0] rd);
    return ((wr ^ rd) == (32'd1 << aw));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_fifo_ctrl_if
// Description : Input stream, output stream and register-file port bundle for
//               the FIFO controller. slave = controller view, master = the
//               surrounding producer/consumer/storage view.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_fifo_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] rf_raddr;
  logic [DATA_WIDTH-1:0] rf_rdata;

  modport slave (
    input  in_valid, in_data, out_ready, rf_rdata,
    output in_ready, out_valid, out_data, rf_wen, rf_waddr, rf_wdata, rf_raddr
  );

  modport master (
    output in_valid, in_data, out_ready, rf_rdata,
    input  in_ready, out_valid, out_data, rf_wen, rf_waddr, rf_wdata, rf_raddr
  );
endinterface
`default_nettype wire

// File: rtl/rf_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : rf_fifo_ptr
// Description : Wrap-bit FIFO pointer with synchronous clear, increment and
//               asynchronous active-low reset. Wraps naturally at 2**WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_fifo_ptr #(
  parameter int unsigned WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic [WIDTH-1:0]      ptr
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Next pointer: clear wins over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  // Pointer register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/rf_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_fifo_ctrl
// Description : Show-ahead FIFO controller owning the register-file write port
//               and read address. Holds pointers, occupancy and status only;
//               data lives in the external register file.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_fifo_ctrl
  import rf_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              flush,
  rf_fifo_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_WIDTH:0]    high_water
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             in_ready_w;
  logic             out_valid_w;
  logic [PTR_W-1:0] count_w;
  logic [PTR_W-1:0] count_nxt;
  logic [PTR_W-1:0] high_water_q;
  logic [PTR_W-1:0] high_water_d;

  rf_fifo_ptr #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  rf_fifo_ptr #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Status is derived purely from the registered pointers.
  assign count_w = wr_ptr - rd_ptr;
  assign empty   = ptrs_empty(32'(wr_ptr), 32'(rd_ptr));
  assign full    = ptrs_full(ADDR_WIDTH, 32'(wr_ptr), 32'(rd_ptr));
  assign count   = count_w;

  // Handshakes are gated by rst_n so both sides read idle while reset is held,
  // and by flush so nothing moves during the clearing cycle. No full bypass:
  // a pop in the same cycle does not reopen in_ready.
  assign in_ready_w  = rst_n & ~full & ~flush;
  assign out_valid_w = rst_n & ~empty & ~flush;
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.rf_wen    = push;
  assign bus.rf_waddr  = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.rf_wdata  = bus.in_data;
  assign bus.rf_raddr  = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.out_data  = bus.rf_rdata;

  // Occupancy after this edge, used to track the high-water mark.
  always_comb begin
    count_nxt = count_w;
    if (push && !pop) begin
      count_nxt = count_w + PTR_W'(1);
    end else if (pop && !push) begin
      count_nxt = count_w - PTR_W'(1);
    end
  end

  // High-water mark: running maximum of occupancy, cleared by flush.
  always_comb begin
    high_water_d = high_water_q;
    if (flush) begin
      high_water_d = '0;
    end else if (count_nxt > high_water_q) begin
      high_water_d = count_nxt;
    end
  end

  // High-water register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water_q <= '0;
    end else begin
      high_water_q <= high_water_d;
    end
  end

  assign high_water = high_water_q;

endmodule
`default_nettype wire
